// File: rtl/ysyx_22041207_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package ysyx_22041207_div_pkg;

  localparam int DIV_XLEN   = 64;
  localparam int WORD_ITER  = 32;
  localparam int DWORD_ITER = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/ysyx_22041207_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, subtract if it fits.
module ysyx_22041207_div_step
  import ysyx_22041207_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] dvs_ext_s;
  logic          fits_s;

  // A set top bit already exceeds any XLEN-bit divisor, so it forces a subtract.
  always_comb begin
    shifted_s = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
    dvs_ext_s = {1'b0, divisor_i};
    fits_s    = rem_i[XLEN] | (shifted_s >= dvs_ext_s);
    if (fits_s) begin
      rem_o = shifted_s - dvs_ext_s;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s;
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ysyx_22041207_div.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and word variants.
module ysyx_22041207_div
  import ysyx_22041207_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic            flush,
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [XLEN-1:0] ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + ONE_X;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  div_state_e      state_q, state_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            negq_q, negq_d, negr_q, negr_d, word_q, word_d;
  logic            ready_q, ready_d, valid_q, valid_d;
  logic [XLEN-1:0] quot_q, quot_d, rmd_q, rmd_d;

  logic [XLEN-1:0] a_ext_s, b_ext_s, a_abs_s, b_abs_s;
  logic            a_neg_s, b_neg_s, b_zero_s, ovf_s;
  logic [XLEN-1:0] q_mag_s, q_fix_s, r_fix_s;
  logic [XLEN:0]   step_rem_s;
  logic [XLEN-1:0] step_quo_s;

  ysyx_22041207_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Operand preparation: effective-width extension, magnitudes and special-case detection.
  always_comb begin
    if (divw) begin
      a_ext_s = div_signed ? sext32(dividend[31:0]) : {{(XLEN-32){1'b0}}, dividend[31:0]};
      b_ext_s = div_signed ? sext32(divisor[31:0])  : {{(XLEN-32){1'b0}}, divisor[31:0]};
    end else begin
      a_ext_s = dividend;
      b_ext_s = divisor;
    end
    a_neg_s  = div_signed & a_ext_s[XLEN-1];
    b_neg_s  = div_signed & b_ext_s[XLEN-1];
    a_abs_s  = a_neg_s ? neg(a_ext_s) : a_ext_s;
    b_abs_s  = b_neg_s ? neg(b_ext_s) : b_ext_s;
    b_zero_s = (b_ext_s == '0);
    ovf_s    = div_signed & (a_ext_s == (divw ? sext32(32'h8000_0000) : MIN_X)) & (b_ext_s == '1);
  end

  // Sign fix-up of the magnitudes; word results are always sign-extended from bit 31.
  always_comb begin
    q_mag_s = word_q ? {{(XLEN-32){1'b0}}, quo_q[31:0]} : quo_q;
    q_fix_s = negq_q ? neg(q_mag_s) : q_mag_s;
    r_fix_s = negr_q ? neg(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    if (word_q) begin
      q_fix_s = sext32(q_fix_s[31:0]);
      r_fix_s = sext32(r_fix_s[31:0]);
    end else begin
      q_fix_s = q_fix_s;
      r_fix_s = r_fix_s;
    end
  end

  // Next-state and datapath update; flush overrides every state.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    word_d  = word_q;
    valid_d = 1'b0;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_valid) begin
            word_d = divw;
            negq_d = a_neg_s ^ b_neg_s;
            negr_d = a_neg_s;
            dvs_d  = b_abs_s;
            cnt_d  = divw ? 6'(WORD_ITER - 1) : 6'(DWORD_ITER - 1);
            if (b_zero_s) begin
              quo_d   = '1;
              rem_d   = {1'b0, (divw ? sext32(dividend[31:0]) : dividend)};
              state_d = DIV_DONE;
            end else if (ovf_s) begin
              quo_d   = a_ext_s;
              rem_d   = '0;
              state_d = DIV_DONE;
            end else begin
              // Word operands sit in the upper half so 32 shifts consume exactly their bits.
              quo_d   = divw ? {a_abs_s[31:0], {(XLEN-32){1'b0}}} : a_abs_s;
              rem_d   = '0;
              state_d = DIV_CALC;
            end
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == 6'd0) begin
            state_d = DIV_FIX;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DIV_FIX: begin
          quo_d   = q_fix_s;
          rem_d   = {1'b0, r_fix_s};
          state_d = DIV_DONE;
        end
        DIV_DONE: begin
          valid_d = 1'b1;
          quot_d  = quo_q;
          rmd_d   = rem_q[XLEN-1:0];
          state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
    ready_d = (state_d == DIV_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= 6'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      word_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
    end
  end

  assign div_ready = ready_q;
  assign out_valid = valid_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Directed bench for ysyx_22041207_div with an arithmetic reference model and per-cycle checking.
module tb_ysyx_22041207_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_valid, flush, div_signed, divw;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  ysyx_22041207_div dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .flush(flush),
    .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        active = 1'b0;
  logic [63:0] exp_q, exp_r;
  logic [63:0] prev_q = 64'd0;
  logic [63:0] prev_r = 64'd0;
  int          acc_cyc, done_cyc;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: RISC-V M-extension results computed with plain arithmetic, plus expected latency.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                       output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [31:0]        a32, b32, q32, r32;
    logic signed [31:0] sa, sb;
    logic signed [63:0] sa64, sb64;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = {{32{a32[31]}}, a32}; lat = 1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = 64'hFFFF_FFFF_8000_0000; r = 64'd0; lat = 1;
      end else begin
        if (s) begin
          sa = a32; sb = b32; q32 = sa / sb; r32 = sa % sb;
        end else begin
          q32 = a32 / b32; r32 = a32 % b32;
        end
        q = {{32{q32[31]}}, q32}; r = {{32{r32[31]}}, r32}; lat = 34;
      end
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0; lat = 1;
      end else begin
        if (s) begin
          sa64 = a; sb64 = b; q = sa64 / sb64; r = sa64 % sb64;
        end else begin
          q = a / b; r = a % b;
        end
        lat = 66;
      end
    end
  endtask

  task automatic compare();
    logic ev, er;
    ev = active && (cyc == done_cyc);
    er = !(active && cyc >= acc_cyc && cyc < done_cyc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("div_ready", {63'd0, div_ready}, {63'd0, er});
    if (active && cyc >= done_cyc) begin
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
    end else if (!active) begin
      chk("quotient_hold", quotient, prev_q);
      chk("remainder_hold", remainder, prev_r);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    #1;
  endtask

  task automatic settle();
    if (active) begin
      prev_q = exp_q;
      prev_r = exp_r;
      active = 1'b0;
    end
  endtask

  task automatic req(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    int lat;
    settle();
    dividend = a; divisor = b; div_signed = s; divw = w; div_valid = 1'b1;
    model(a, b, s, w, exp_q, exp_r, lat);
    acc_cyc  = cyc + 1;
    done_cyc = acc_cyc + lat;
    active   = 1'b1;
    step();
    div_valid  = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    div_signed = 1'($urandom_range(1));
    divw       = 1'($urandom_range(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && cyc < done_cyc; i++) step();
    if (cyc < done_cyc) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: still busy at cycle %0d, want done by %0d", cyc, done_cyc);
    end
    settle();
  endtask

  task automatic pin(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                     input logic [63:0] eq, input logic [63:0] er, input int elat);
    logic [63:0] q, r;
    int          lat;
    model(a, b, s, w, q, r, lat);
    chk("pin_quotient", q, eq);
    chk("pin_remainder", r, er);
    chk("pin_latency", 64'(lat), 64'(elat));
    req(a, b, s, w);
    wait_done();
  endtask

  initial begin
    div_valid = 1'b0; flush = 1'b0; div_signed = 1'b0; divw = 1'b0;
    dividend = 64'd0; divisor = 64'd0;
    rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();

    pin(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66);
    pin(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    pin(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
    pin(64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    pin(64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    pin(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1);
    pin(64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    pin(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 34);
    pin(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 66);
    pin(64'hABCD_0000_8000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    pin(64'h0000_0000_0000_0064, 64'hFFFF_FFFF_0000_0007, 1'b0, 1'b1, 64'd14, 64'd2, 34);
    pin(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66);

    // Flush 10 cycles into an operation, then an immediate new request.
    req(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (9) step();
    flush = 1'b1; active = 1'b0;
    step();
    flush = 1'b0;
    req(64'd100, 64'd7, 1'b0, 1'b0);
    wait_done();

    // Flush together with a request in IDLE must not start anything.
    dividend = 64'd9; divisor = 64'd4; div_signed = 1'b0; divw = 1'b0;
    div_valid = 1'b1; flush = 1'b1;
    step();
    div_valid = 1'b0; flush = 1'b0;
    repeat (4) step();

    // Flush while DONE suppresses the pulse and keeps the old results.
    req(64'd5, 64'd0, 1'b0, 1'b0);
    flush = 1'b1; active = 1'b0;
    step();
    flush = 1'b0;
    repeat (3) step();

    // Asynchronous reset mid-CALC, then a request on the first post-reset cycle.
    req(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0);
    repeat (20) step();
    rst = 1'b0; active = 1'b0; prev_q = 64'd0; prev_r = 64'd0;
    step(); step();
    rst = 1'b1;
    req(64'd100, 64'd7, 1'b0, 1'b0);
    wait_done();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
